iecdrv_rom_arb: RTL and testbench

//  Shares one external ROM read port (SDRAM/BRAM bridge) between NDRV IEC drive instances.

---
 rtl/iecdrv_pkg.sv | 10 +
 rtl/iecdrv_rr_pick.sv | 27 ++
 rtl/iecdrv_rom_arb.sv | 141 ++++++++++++++
 tb/tb_iecdrv_rom_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iecdrv_pkg.sv
// rtl/iecdrv_pkg.sv - shared types and constants for the IEC drive ROM arbiter
package iecdrv_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    localparam int         ROM_AW         = 15;
    localparam int         ROM_DW         = 8;
    localparam logic [7:0] ROM_RESET_DATA = 8'hFF;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// rtl/iecdrv_rr_pick.sv - combinational round-robin picker: first set pend bit at or after rr_ptr
module iecdrv_rr_pick #(
    parameter int NDRV = 2,
    parameter int IW   = 1
) (
    input  logic [NDRV-1:0] pend,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    // Scan NDRV positions starting at rr_ptr, wrapping to 0; keep the first hit
    always_comb begin
        int c;
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < NDRV; k++) begin
            c = (int'(rr_ptr) + k) % NDRV;
            if (!any && pend[c]) begin
                any = 1'b1;
                idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/iecdrv_rom_arb.sv
// rtl/iecdrv_rom_arb.sv - shares one ROM read port between NDRV drives; IECDRV_ROM_ARB_CACHE_EN adds a last-address tag per drive
module iecdrv_rom_arb
    import iecdrv_pkg::*;
#(
    parameter int NDRV = 2,
    parameter int AW   = ROM_AW,
    parameter int DW   = ROM_DW,
    parameter int IW   = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [NDRV-1:0]    req,
    input  logic [NDRV*AW-1:0] addr,
    output logic [NDRV-1:0]    ack,
    output logic [NDRV*DW-1:0] data,
    output logic               mem_req,
    output logic [IW+AW-1:0]   mem_addr,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_data,
    output logic               busy,
    output logic [NDRV-1:0]    ovf
);

    arb_state_t      state, state_nx;
    logic [NDRV-1:0] pend, done_vec, accept, hit, ack_r, ovf_r;
    logic [AW-1:0]   a_lat  [NDRV];
    logic [DW-1:0]   data_r [NDRV];
    logic [IW-1:0]   gnt, rr_ptr, rr_next, pick_idx;
    logic            pick_any, done;

`ifdef IECDRV_ROM_ARB_CACHE_EN
    logic [AW-1:0]   tag [NDRV];
    logic [NDRV-1:0] tag_v;
`endif

    iecdrv_rr_pick #(.NDRV(NDRV), .IW(IW)) u_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign done    = (state == ARB_WAIT) && mem_ack;
    assign rr_next = (int'(gnt) == NDRV - 1) ? '0 : gnt + 1'b1;

    // Classify each drive's strobe: completing lane, accepted request, tag hit
    always_comb begin
        done_vec = '0;
        accept   = '0;
        hit      = '0;
        for (int i = 0; i < NDRV; i++) begin
            done_vec[i] = done && (int'(gnt) == i);
            // A strobe on the completion cycle counts as a fresh request
            accept[i]   = req[i] && (!pend[i] || done_vec[i]);
`ifdef IECDRV_ROM_ARB_CACHE_EN
            // On completion the tag about to be written is the one that matters
            hit[i] = accept[i] && (done_vec[i] || tag_v[i]) &&
                     (addr[i*AW +: AW] == (done_vec[i] ? a_lat[i] : tag[i]));
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= ARB_IDLE;
        else        state <= state_nx;
    end

    // FSM next state: IDLE grants when anything is pending, WAIT ends on mem_ack
    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE: if (pick_any) state_nx = ARB_WAIT;
            ARB_WAIT: if (mem_ack)  state_nx = ARB_IDLE;
            default:  state_nx = ARB_IDLE;
        endcase
    end

    // Request latches, overflow flags, memory port and per-drive data/ack registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pend     <= '0;
            ovf_r    <= '0;
            ack_r    <= '0;
            gnt      <= '0;
            rr_ptr   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            for (int i = 0; i < NDRV; i++) begin
                a_lat[i]  <= '0;
                data_r[i] <= DW'(ROM_RESET_DATA);
            end
        end else begin
            ack_r <= done_vec | hit;
            for (int i = 0; i < NDRV; i++) begin
                if (done_vec[i]) data_r[i] <= mem_data;
                if (accept[i] && !hit[i]) begin
                    pend[i]  <= 1'b1;
                    a_lat[i] <= addr[i*AW +: AW];
                end else if (done_vec[i]) begin
                    pend[i]  <= 1'b0;
                end
                if (req[i] && !accept[i]) ovf_r[i] <= 1'b1;
            end
            if (state == ARB_IDLE && pick_any) begin
                gnt      <= pick_idx;
                mem_addr <= {pick_idx, a_lat[pick_idx]};
                mem_req  <= 1'b1;
            end else if (done) begin
                mem_req  <= 1'b0;
                rr_ptr   <= rr_next;
            end
        end
    end

`ifdef IECDRV_ROM_ARB_CACHE_EN
    // Remember the last address fetched from memory for each drive
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            tag_v <= '0;
            for (int i = 0; i < NDRV; i++) tag[i] <= '0;
        end else begin
            for (int i = 0; i < NDRV; i++) begin
                if (done_vec[i]) begin
                    tag[i]   <= a_lat[i];
                    tag_v[i] <= 1'b1;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NDRV; g++) begin : g_lane
        assign data[g*DW +: DW] = data_r[g];
    end

    assign ack  = ack_r;
    assign ovf  = ovf_r;
    assign busy = (|pend) || (state == ARB_WAIT);

endmodule

// File: tb/tb_iecdrv_rom_arb.sv
// tb/tb_iecdrv_rom_arb.sv - scoreboard bench for iecdrv_rom_arb, directed scenarios plus random traffic
module tb_iecdrv_rom_arb;
    localparam int NDRV = 2;
    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int IW   = 1;
`ifdef IECDRV_ROM_ARB_CACHE_EN
    localparam int T6_MEMREQS = 1;
`else
    localparam int T6_MEMREQS = 2;
`endif

    logic               clk = 1'b0;
    logic               res_n;
    logic [NDRV-1:0]    req;
    logic [NDRV*AW-1:0] addr;
    logic [NDRV-1:0]    ack;
    logic [NDRV*DW-1:0] data;
    logic               mem_req;
    logic [IW+AW-1:0]   mem_addr;
    logic               mem_ack;
    logic [DW-1:0]      mem_data;
    logic               busy;
    logic [NDRV-1:0]    ovf;

    iecdrv_rom_arb #(.NDRV(NDRV), .AW(AW), .DW(DW), .IW(IW)) dut (
        .clk(clk), .res_n(res_n), .req(req), .addr(addr), .ack(ack), .data(data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ROM contents seen by the bench memory; one fixed word for the single-fetch scenario
    function automatic logic [7:0] memf(input logic [15:0] a);
        logic [15:0] h;
        if (a == 16'h7F00) return 8'hA5;
        h = (a * 16'd40503) ^ (a >> 5);
        return h[11:4];
    endfunction

    // Memory responder: random or fixed latency, optional stray acks while idle
    int lat_cfg = -1;
    bit mem_auto = 1'b1, spur_en = 1'b0, man_ack = 1'b0;
    function automatic int pick_lat();
        return (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
    endfunction
    initial begin : mem_drv
        int lat;
        lat = 0; mem_ack = 1'b0; mem_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_auto) begin
                mem_ack = man_ack;
                mem_data = 8'h5A;
            end else if (!res_n) begin
                lat = pick_lat();
            end else if (mem_req) begin
                if (lat == 0) begin
                    mem_ack = 1'b1; mem_data = memf(mem_addr); lat = pick_lat();
                end else lat--;
            end else begin
                lat = pick_lat();
                if (spur_en && $urandom_range(0, 7) == 0) begin
                    mem_ack = 1'b1; mem_data = 8'($urandom);
                end
            end
        end
    end

    // Reference model state: what the arbiter should hold, derived from the rules
    typedef struct { int drv; int cyc; logic [7:0] d; } exp_t;
    exp_t          exp_q[$];
    bit [NDRV-1:0] m_pend, m_ovf, m_tag_v;
    logic [AW-1:0] m_addr [NDRV];
    logic [AW-1:0] m_tag  [NDRV];
    logic [DW-1:0] m_data [NDRV];
    bit            m_inflight;
    int            m_gnt, m_rr;

    // Model: check architectural outputs, then advance the model over the coming edge
    always @(negedge clk) begin : model
        bit was_inf, done_m, comp, hitm;
        int g;
        if (!res_n) begin
            m_pend = '0; m_ovf = '0; m_tag_v = '0; m_inflight = 1'b0; m_gnt = 0; m_rr = 0;
            for (int i = 0; i < NDRV; i++) m_data[i] = 8'hFF;
            exp_q.delete();
        end else begin
            chk("busy", busy, 32'((|m_pend) || m_inflight));
            chk("mem_req", mem_req, 32'(m_inflight));
            if (m_inflight) chk("mem_addr", mem_addr, 32'({IW'(m_gnt), m_addr[m_gnt]}));
            chk("ovf", ovf, m_ovf);
            for (int i = 0; i < NDRV; i++) chk("data_lane", data[i*DW +: DW], m_data[i]);
            was_inf = m_inflight;
            done_m  = was_inf && mem_ack;
            if (!was_inf && |m_pend) begin
                g = -1;
                for (int k = 0; k < NDRV; k++)
                    if (g < 0 && m_pend[(m_rr + k) % NDRV]) g = (m_rr + k) % NDRV;
                m_gnt = g; m_inflight = 1'b1;
            end
            for (int i = 0; i < NDRV; i++) begin
                comp = done_m && (m_gnt == i);
                hitm = 1'b0;
                if (comp) begin
                    m_pend[i] = 1'b0;
                    m_data[i] = memf({IW'(i), m_addr[i]});
                    m_tag[i] = m_addr[i]; m_tag_v[i] = 1'b1;
                    exp_q.push_back('{i, cyc + 1, m_data[i]});
                end
                if (req[i]) begin
                    if (!m_pend[i]) begin
`ifdef IECDRV_ROM_ARB_CACHE_EN
                        hitm = m_tag_v[i] && (addr[i*AW +: AW] == m_tag[i]);
`endif
                        if (hitm) begin
                            if (!comp) exp_q.push_back('{i, cyc + 1, m_data[i]});
                        end else begin
                            m_pend[i] = 1'b1; m_addr[i] = addr[i*AW +: AW];
                        end
                    end else m_ovf[i] = 1'b1;
                end
            end
            if (done_m) begin m_inflight = 1'b0; m_rr = (m_gnt + 1) % NDRV; end
        end
    end

    // Monitor: pop expected acks as the DUT presents them; log every memory access
    logic [15:0] grant_log[$];
    int          n_ack [NDRV];
    int          n_memreq = 0;
    bit          mreq_prev = 1'b0;
    initial for (int i = 0; i < NDRV; i++) n_ack[i] = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!res_n) mreq_prev = 1'b0;
        else begin
            if (mem_req && !mreq_prev) begin grant_log.push_back(mem_addr); n_memreq++; end
            mreq_prev = mem_req;
            for (int i = 0; i < NDRV; i++) begin
                if (ack[i]) begin
                    n_ack[i]++;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL ack_unexpected: drive %0d acked with nothing expected (cycle %0d)", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_drive", i, e.drv);
                        chk("ack_cycle", cyc, e.cyc);
                        chk("ack_data", data[i*DW +: DW], e.d);
                    end
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                n_chk++; n_fail++;
                $display("FAIL ack_missing: drive %0d no ack, expected at cycle %0d (cycle %0d)", exp_q[0].drv, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic drive(input logic [NDRV-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        req = r; addr = {a1, a0}; tick(); req = '0;
    endtask
    task automatic do_reset();
        res_n = 1'b0; tick(); tick(); res_n = 1'b1; tick();
        grant_log.delete();
    endtask
    task automatic idle_wait(input string nm, input int maxc);
        int k;
        k = 0;
        while ((busy || mem_req) && k < maxc) begin tick(); k++; end
        chk(nm, 32'(k < maxc), 32'd1);
        tick(); tick();
    endtask
    task automatic wait_mem_req(input string nm, input int maxc);
        int k;
        k = 0;
        while (!mem_req && k < maxc) begin tick(); k++; end
        chk(nm, 32'(mem_req), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b0, b1;
        logic [NDRV-1:0] r;
        res_n = 1'b0; req = '0; addr = '0;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_data", data, 16'hFFFF);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        res_n = 1'b1; tick();

        // 1: single fetch, memory answers two cycles after mem_req
        lat_cfg = 2; b0 = n_ack[0];
        drive(2'b01, 15'h7F00, 15'h0);
        idle_wait("t1_drain", 40);
        chk("t1_nacc", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t1_mem_addr", grant_log[0], 16'h07F00);
        chk("t1_ack0_once", n_ack[0] - b0, 1);
        chk("t1_data0", data[7:0], 8'hA5);
        chk("t1_data1", data[15:8], 8'hFF);
        chk("t1_busy", busy, 0);

        // 2: collision with rr_ptr at 0, then confirm the pointer wrapped back to 0
        do_reset(); lat_cfg = 1;
        drive(2'b11, 15'h0010, 15'h0020);
        idle_wait("t2_drain", 40);
        chk("t2_nacc", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t2_first", grant_log[0], 16'h00010);
            chk("t2_second", grant_log[1], 16'h08020);
        end
        grant_log.delete();
        drive(2'b11, 15'h0030, 15'h0040);
        idle_wait("t2b_drain", 40);
        if (grant_log.size() > 0) chk("t2_rr_back_to_0", grant_log[0][15], 0);

        // 3: both drives re-request on every ack; grants must alternate
        do_reset(); lat_cfg = 1;
        drive(2'b11, 15'h0400, 15'h0500);
        for (int c = 0; c < 60; c++) begin
            req = ack; addr = {15'(c + 'h700), 15'(c + 'h600)}; tick();
        end
        req = '0;
        idle_wait("t3_drain", 40);
        chk("t3_enough", 32'(grant_log.size() >= 8), 1);
        for (int k = 0; k < grant_log.size(); k++) chk("t3_alternate", grant_log[k][15], k % 2);

        // 4: overflow while pending, then a re-request on the exact completion cycle
        do_reset(); lat_cfg = 3;
        drive(2'b10, 15'h0, 15'h0100);
        drive(2'b10, 15'h0, 15'h0200);
        b1 = 0;
        while (b1 < 20) begin @(posedge clk); #2; if (mem_ack) break; b1++; end
        chk("t4_saw_ack_cycle", 32'(b1 < 20), 1);
        req = 2'b10; addr = {15'h0300, 15'h0};
        @(posedge clk); #1; req = '0;
        idle_wait("t4_drain", 40);
        chk("t4_ovf", ovf, 2'b10);
        chk("t4_nacc", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t4_first_addr", grant_log[0], 16'h08100);
            chk("t4_second_addr", grant_log[1], 16'h08300);
        end

        // 5: reset while WAIT, then a late mem_ack after release
        do_reset(); lat_cfg = 10;
        drive(2'b01, 15'h0042, 15'h0);
        wait_mem_req("t5_mem_req", 10);
        mem_auto = 1'b0; man_ack = 1'b0;
        res_n = 1'b0; tick();
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        chk("t5_rst_data", data, 16'hFFFF);
        res_n = 1'b1; b0 = n_ack[0] + n_ack[1];
        tick(); man_ack = 1'b1; tick(); man_ack = 1'b0; tick(); tick();
        mem_auto = 1'b1;
        chk("t5_no_ack", n_ack[0] + n_ack[1] - b0, 0);
        chk("t5_data", data, 16'hFFFF);
        chk("t5_busy", busy, 0);

        // 6: same address twice from drive 0
        do_reset(); lat_cfg = 1; b0 = n_memreq;
        drive(2'b01, 15'h1234, 15'h0);
        idle_wait("t6a_drain", 40);
        drive(2'b01, 15'h1234, 15'h0);
        idle_wait("t6b_drain", 40);
        chk("t6_memreqs", n_memreq - b0, T6_MEMREQS);

        // Random traffic with random latency and stray idle acks
        do_reset(); lat_cfg = -1; spur_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NDRV; i++) r[i] = ($urandom_range(0, 3) == 0);
            req = r;
            addr = {15'($urandom_range(0, 3) * 'h222), 15'($urandom_range(0, 3) * 'h111)};
            tick();
        end
        req = '0; spur_en = 1'b0;
        idle_wait("rand_drain", 60);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
